// File: rtl/uart_pkg.sv
// Shared UART definitions: tx FSM state encoding, line levels and the
// count-width helper used to size FIFO occupancy counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO. Writes while full and reads while empty are
// ignored; a simultaneous push and pop leaves the count unchanged.
// rd_data_o always shows the oldest entry (first-word fall-through).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             wr_en_i,
  input  logic [DATA_BITS-1:0]             wr_data_i,
  input  logic                             rd_en_i,
  output logic [DATA_BITS-1:0]             rd_data_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic [count_w(FIFO_DEPTH)-1:0]   count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = count_w(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Storage array: no reset needed, contents are qualified by count_q.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy; pointers wrap naturally (depth is a power of 2).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: synchronises the divider's uart_clock into a
// one-cycle bit_tick, buffers bytes in uart_tx_fifo and shifts each out as
// start + data (LSB first) + [parity] + stop bits on tx.
// Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                           physical_clock,
  input  logic                           reset_n,
  input  logic                           uart_clock,
  input  logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic                           tx,
  output logic                           busy,
  output logic [count_w(FIFO_DEPTH)-1:0] fifo_count,
  output tx_state_e                      dbg_state
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("PARITY_ODD must be 0 or 1");
  end

  // Handshake: a byte is accepted on any posedge where tx_valid && tx_ready;
  // tx_ready depends only on FIFO occupancy, never on tx_valid.

  logic                 sync1_q, sync2_q, edge_q;
  logic                 bit_tick;
  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 fifo_rd_en, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (physical_clock),
    .rst_ni   (reset_n),
    .wr_en_i  (tx_valid),
    .wr_data_i(tx_data),
    .rd_en_i  (fifo_rd_en),
    .rd_data_o(fifo_rd_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
  assign bit_tick  = sync2_q && !edge_q;

  // Synchroniser and edge register; reset high so a high uart_clock at
  // reset release is not mistaken for a rising edge.
  always_ff @(posedge physical_clock) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
    end else begin
      sync1_q <= uart_clock;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  // FSM state, line driver and shift register.
  always_ff @(posedge physical_clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic: everything advances only on bit_tick, so a stalled
  // uart_clock freezes the frame in place.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    fifo_rd_en = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    if (bit_tick) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_rd_en = 1'b1;
            shift_d    = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_d   = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
            tx_d       = UART_START_LEVEL;
            busy_d     = 1'b1;
            state_d    = START;
          end
        end
        START: begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = DATA;
        end
        DATA: begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d       = parity_q;
            state_d    = PARITY;
`else
            tx_d       = UART_IDLE_LEVEL;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_d       = UART_IDLE_LEVEL;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
`endif
        STOP: begin
          if (stop_cnt_q == LAST_STOP) begin
            if (!fifo_empty) begin
              // Back-to-back frame: start bit directly after the last stop bit.
              fifo_rd_en = 1'b1;
              shift_d    = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
              parity_d   = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
              tx_d       = UART_START_LEVEL;
              state_d    = START;
            end else begin
              tx_d    = UART_IDLE_LEVEL;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_d    = UART_IDLE_LEVEL;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer (DATA_BITS=8, FIFO_DEPTH=4, STOP_BITS=1).
// Each expected bit tick is a {busy, tx} pair queued by the driver; the
// monitor samples the line after every uart_clock rising edge and pops.
module tb_uart_tx_serializer;

  localparam int DB            = 8;
  localparam int DEPTH         = 4;
  localparam int TB_STOP_BITS  = 1;
  localparam int TB_PARITY_ODD = 0;
  localparam int HALF          = 8;

  logic          physical_clock = 1'b0;
  logic          reset_n        = 1'b0;
  logic          uart_clock     = 1'b0;
  logic [DB-1:0] tx_data        = '0;
  logic          tx_valid       = 1'b0;
  logic          tx_ready, tx, busy;
  logic [2:0]    fifo_count;
  uart_pkg::tx_state_e dbg_state;

  logic [1:0]    exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            tick_n = 0;
  bit            mon_en = 1'b0;

  uart_tx_serializer #(
    .DATA_BITS (DB),
    .FIFO_DEPTH(DEPTH),
    .STOP_BITS (TB_STOP_BITS),
    .PARITY_ODD(TB_PARITY_ODD)
  ) dut (
    .physical_clock(physical_clock),
    .reset_n       (reset_n),
    .uart_clock    (uart_clock),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 physical_clock = ~physical_clock;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Driver tasks
  task automatic write_byte(input logic [DB-1:0] d);
    @(negedge physical_clock);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge physical_clock);
    tx_valid = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      uart_clock = 1'b1;
      repeat (HALF) @(negedge physical_clock);
      uart_clock = 1'b0;
      repeat (HALF) @(negedge physical_clock);
    end
  endtask

  task automatic push_frame(input logic [DB-1:0] d);
    exp_q.push_back(2'b10);                       // start bit
    for (int i = 0; i < DB; i++) exp_q.push_back({1'b1, d[i]});
`ifdef UART_TX_PARITY_EN
    exp_q.push_back({1'b1, (^d) ^ 1'(TB_PARITY_ODD)});
`endif
    for (int i = 0; i < TB_STOP_BITS; i++) exp_q.push_back(2'b11);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b01);
  endtask

  task automatic pulse_reset();
    @(negedge physical_clock);
    reset_n = 1'b0;
    @(negedge physical_clock);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(fifo_count), 0);
    reset_n = 1'b1;
  endtask

  // Monitor: one {busy, tx} sample per bit tick, settled 5 cycles after the rise.
  initial begin
    logic [1:0] act, exp;
    forever begin
      @(posedge uart_clock);
      if (mon_en) begin
        repeat (5) @(negedge physical_clock);
        act = {busy, tx};
        tick_n++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tick_unexpected: tick %0d got busy,tx=%b with nothing queued", tick_n, act);
        end else begin
          exp = exp_q.pop_front();
          total++;
          if (act !== exp) begin
            bad++;
            $display("FAIL tick %0d: got busy,tx=%b expected %b", tick_n, act, exp);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset state
    repeat (3) @(negedge physical_clock);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_ready", int'(tx_ready), 1);
    reset_n = 1'b1;
    repeat (4) @(negedge physical_clock);
    mon_en = 1'b1;

    // 1: single frame 0xA5 -> 0,1,0,1,0,0,1,0,1,1 then idle
    write_byte(8'hA5);
    push_frame(8'hA5);
    push_idle(2);
    run_ticks(2 + DB + TB_STOP_BITS + 1
`ifdef UART_TX_PARITY_EN
              + 1
`endif
             );

    // 2: FIFO fill with uart_clock held low; 5th byte dropped
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    check("fill3_ready", int'(tx_ready), 1);
    write_byte(8'h44);
    check("full_ready", int'(tx_ready), 0);
    check("full_count", int'(fifo_count), 4);
    write_byte(8'h55);
    check("drop_count", int'(fifo_count), 4);
    push_frame(8'h11);
    push_frame(8'h22);
    push_frame(8'h33);
    push_frame(8'h44);
    push_idle(3);
    run_ticks(exp_q.size());
    check("drain_count", int'(fifo_count), 0);

    // 3: back-to-back frames 0x00, 0xFF with no idle tick between
    write_byte(8'h00);
    write_byte(8'hFF);
    push_frame(8'h00);
    push_frame(8'hFF);
    push_idle(2);
    run_ticks(exp_q.size());

    // 4: reset during data bit 3 of 0x3C (bits 0,0,1,1), queued 0x5A flushed
    write_byte(8'h3C);
    write_byte(8'h5A);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b11);
    run_ticks(5);
    pulse_reset();
    push_idle(12);
    run_ticks(12);

    // 5: uart_clock high at reset release, FIFO loaded later
    mon_en = 1'b0;
    @(negedge physical_clock);
    uart_clock = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge physical_clock);
    reset_n = 1'b1;
    repeat (10) @(negedge physical_clock);
    write_byte(8'h96);
    repeat (20) @(negedge physical_clock);
    check("hi_release_tx", int'(tx), 1);
    check("hi_release_busy", int'(busy), 0);
    check("hi_release_count", int'(fifo_count), 1);
    uart_clock = 1'b0;
    repeat (HALF) @(negedge physical_clock);
    mon_en = 1'b1;
    push_frame(8'h96);
    push_idle(2);
    run_ticks(exp_q.size());

    repeat (5) @(negedge physical_clock);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
